// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: RV32I funct3 codes,
// FSM state type, and the lane steering / load extension helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Unsigned load codes have no store counterpart.
    function automatic logic f3_legal(logic [2:0] f3, logic we);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    // Byte lane of the access after truncation to natural alignment.
    function automatic logic [1:0] lane_of(logic [2:0] f3, logic [1:0] a);
        case (f3)
            F3_B, F3_BU: return a;
            F3_H, F3_HU: return {a[1], 1'b0};
            default:     return 2'b00;
        endcase
    endfunction

    function automatic logic misaligned(logic [2:0] f3, logic [1:0] a);
        case (f3)
            F3_H, F3_HU: return a[0];
            F3_W:        return a != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(logic [2:0] f3, logic [1:0] lane);
        case (f3)
            F3_B:    return 4'b0001 << lane;
            F3_H:    return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data so every lane carries it; the strobe picks.
    function automatic logic [31:0] store_data(logic [2:0] f3, logic [31:0] wdata);
        case (f3)
            F3_B:    return {4{wdata[7:0]}};
            F3_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(logic [2:0] f3, logic [31:0] word,
                                                logic [1:0] lane);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (f3)
            F3_B:    return {{24{sh[7]}}, sh[7:0]};
            F3_BU:   return {24'd0, sh[7:0]};
            F3_H:    return {{16{sh[15]}}, sh[15:0]};
            F3_HU:   return {16'd0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port WORDS x 32 storage with byte strobes and a registered read port.
// Ports: clk, rst_n, en_i (access), we_i (1 = write), addr_i (word index),
//        strb_i (byte enables), wdata_i, rdata_o (word read at the last read access).
// Storage contents are not reset; only the read register is.
module dmem_array #(
    parameter int unsigned WORDS = 65536
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(WORDS)-1:0] addr_i,
    input  logic [3:0]               strb_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;

    // Byte-strobed write
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Read register only updates on a read, so it holds between accesses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else if (en_i && !we_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// RV32I load/store data memory with valid/ready request, LATENCY wait states
// and a one-cycle response pulse carrying extended load data and an error flag.
// Ports: clk, rst_n, req_valid/req_ready handshake, req_we, req_addr (byte),
//        req_funct3, req_wdata; rsp_valid, rsp_rdata, rsp_err.
// Build option: DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into
// errors; otherwise low address bits are truncated to natural alignment.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned WORDS   = 65536,
    parameter int unsigned LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW        = $clog2(WORDS);
    localparam bit          HAS_WAIT  = (LATENCY != 0);
    localparam logic [2:0]  WAIT_LOAD = HAS_WAIT ? 3'(LATENCY - 1) : 3'd0;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        accept;
    logic [29:0] idx;
    logic [1:0]  lane;
    logic        in_range, align_err, req_err, mem_en;
    // Fields of the in-flight request, consumed when the response is shown
    logic        err_q, zero_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    // Last shown response, displayed between pulses
    logic        err_hold_q;
    logic [31:0] rdata_hold_q;
    logic [31:0] arr_rdata, live_rdata;

    assign req_ready = rst_n && (state_q != ST_WAIT);
    assign accept    = req_valid && req_ready;

    // Request decode
    assign idx      = req_addr[31:2];
    assign lane     = lane_of(req_funct3, req_addr[1:0]);
    assign in_range = 32'(idx) < 32'(WORDS);
`ifdef DMEM_MISALIGN_TRAP_EN
    assign align_err = misaligned(req_funct3, req_addr[1:0]);
`else
    assign align_err = 1'b0;
`endif
    assign req_err = !f3_legal(req_funct3, req_we) || !in_range || align_err;
    assign mem_en  = accept && !req_err;

    dmem_array #(.WORDS(WORDS)) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (mem_en),
        .we_i    (req_we),
        .addr_i  (AW'(idx)),
        .strb_i  (store_strb(req_funct3, lane)),
        .wdata_i (store_data(req_funct3, req_wdata)),
        .rdata_o (arr_rdata)
    );

    // Next-state logic; RESP accepts like IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    state_d = HAS_WAIT ? ST_WAIT : ST_RESP;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 3'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            err_q        <= 1'b0;
            zero_q       <= 1'b0;
            f3_q         <= F3_W;
            lane_q       <= 2'b00;
            err_hold_q   <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                err_q  <= req_err;
                zero_q <= req_we || req_err;
                f3_q   <= req_funct3;
                lane_q <= lane;
            end
            if (rsp_valid) begin
                err_hold_q   <= err_q;
                rdata_hold_q <= live_rdata;
            end
        end
    end

    // Response: live data during the pulse, previous response otherwise
    assign live_rdata = zero_q ? 32'd0 : load_extend(f3_q, arr_rdata, lane_q);
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_rdata  = rsp_valid ? live_rdata : rdata_hold_q;
    assign rsp_err    = rsp_valid ? err_q : err_hold_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: instance 0 with LATENCY=0, instance 1 with LATENCY=3,
// both WORDS=64. A byte-level memory model predicts every output each cycle;
// directed requests also carry hand-computed expected responses.
module tb_data_mem_ctrl;

    localparam int unsigned NW = 64;

    logic        clk;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [2:0]  req_funct3[2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    data_mem_ctrl #(.WORDS(NW), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_funct3(req_funct3[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_ctrl #(.WORDS(NW), .LATENCY(3)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_funct3(req_funct3[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model state ----------------
    logic [7:0]  mem    [2][NW*4];
    int          free_c [2];
    int          resp_c [2];
    logic [31:0] pend_d [2];
    logic        pend_e [2];
    logic [31:0] held_d [2];
    logic        held_e [2];
    logic        e_rdy, e_v, e_e;
    logic [31:0] e_d;

    function automatic int lat(input int u);
        return (u == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string nm, input int u, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s u%0d cyc %0d: got %h want %h", nm, u, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string nm, input int u);
        n_cmp++;
        n_bad++;
        $display("FAIL %s u%0d cyc %0d: timed out", nm, u, cyc);
    endtask

    // Byte-level RV32I access model producing the pending response
    function automatic void model_access(input int u, input logic we, input logic [31:0] a,
                                         input logic [2:0] f3, input logic [31:0] wd);
        int n, base;
        logic err;
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            3'd2:       n = 4;
            default:    n = 0;
        endcase
        err = (n == 0) || (we && f3[2]) || (a[31:2] >= 30'(NW));
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) err = 1'b1;
`endif
        pend_d[u] = 32'd0;
        pend_e[u] = err;
        if (err) return;
        base = int'(a[7:0]) & ~(n - 1);
        if (we) begin
            for (int i = 0; i < n; i++) mem[u][base+i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mem[u][base+i];
            if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
            pend_d[u] = v;
        end
    endfunction

    // Per-cycle compare, then model update for this cycle's handshake
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                resp_c[u] = -1;
                free_c[u] = 0;
                held_d[u] = 32'd0;
                held_e[u] = 1'b0;
            end
            e_rdy = rst_n && (cyc >= free_c[u]);
            e_v   = rst_n && (cyc == resp_c[u]);
            e_d   = e_v ? pend_d[u] : held_d[u];
            e_e   = e_v ? pend_e[u] : held_e[u];
            chk("req_ready", u, 32'(req_ready[u]), 32'(e_rdy));
            chk("rsp_valid", u, 32'(rsp_valid[u]), 32'(e_v));
            chk("rsp_rdata", u, rsp_rdata[u], e_d);
            chk("rsp_err",   u, 32'(rsp_err[u]), 32'(e_e));
            if (e_v) begin
                held_d[u] = pend_d[u];
                held_e[u] = pend_e[u];
            end
            if (e_rdy && req_valid[u]) begin
                model_access(u, req_we[u], req_addr[u], req_funct3[u], req_wdata[u]);
                resp_c[u] = cyc + 1 + lat(u);
                free_c[u] = cyc + 1 + lat(u);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int u, input logic we, input logic [31:0] a,
                        input logic [2:0] f3, input logic [31:0] wd, output int waits);
        bit got;
        got           = 1'b0;
        waits         = 0;
        req_valid[u]  = 1'b1;
        req_we[u]     = we;
        req_addr[u]   = a;
        req_funct3[u] = f3;
        req_wdata[u]  = wd;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready[u]) got = 1'b1;
            else              waits++;
        end
        if (!got) timeout("accept", u);
        @(posedge clk);
        #1;
        req_valid[u] = 1'b0;
    endtask

    task automatic expect_rsp(input int u, input string nm, input logic [31:0] d,
                              input logic e);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (rsp_valid[u]) begin
                seen = 1'b1;
                chk({nm, "_rdata"}, u, rsp_rdata[u], d);
                chk({nm, "_err"}, u, 32'(rsp_err[u]), 32'(e));
            end
        end
        if (!seen) timeout({nm, "_rsp"}, u);
        @(posedge clk);
        #1;
    endtask

    task automatic access(input int u, input string nm, input logic we, input logic [31:0] a,
                          input logic [2:0] f3, input logic [31:0] wd,
                          input logic [31:0] d, input logic e);
        int w;
        send(u, we, a, f3, wd, w);
        expect_rsp(u, nm, d, e);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        int pulses;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = '0;
            req_funct3[u] = 3'd0; req_wdata[u] = '0;
            pend_d[u] = '0; pend_e[u] = 1'b0; held_d[u] = '0; held_e[u] = 1'b0;
            resp_c[u] = -1; free_c[u] = 0;
            for (int b = 0; b < int'(NW) * 4; b++) mem[u][b] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Known contents everywhere so every load has a defined value
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < int'(NW); i++) send(u, 1'b1, 32'(i * 4), 3'b010, 32'd0, w);
        repeat (5) @(posedge clk);
        #1;

        // LATENCY=0: store then load on consecutive cycles
        send(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, w);
        send(0, 1'b0, 32'h10, 3'b010, 32'd0, w);
        chk("b2b_waits", 0, 32'(w), 32'd0);
        expect_rsp(0, "lw_b2b", 32'hDEADBEEF, 1'b0);

        access(0, "sb",    1'b1, 32'h13, 3'b000, 32'h80, 32'h0, 1'b0);
        access(0, "lb",    1'b0, 32'h13, 3'b000, 32'h0, 32'hFFFFFF80, 1'b0);
        access(0, "lbu",   1'b0, 32'h13, 3'b100, 32'h0, 32'h00000080, 1'b0);
        access(0, "lw_sb", 1'b0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 1'b0);
        access(0, "lb2",   1'b0, 32'h12, 3'b000, 32'h0, 32'hFFFFFFAD, 1'b0);
        access(0, "sh",    1'b1, 32'h22, 3'b001, 32'h1234, 32'h0, 1'b0);
        access(0, "lw_sh", 1'b0, 32'h20, 3'b010, 32'h0, 32'h12340000, 1'b0);
        access(0, "lh",    1'b0, 32'h22, 3'b001, 32'h0, 32'h00001234, 1'b0);
        access(0, "sh2",   1'b1, 32'h20, 3'b001, 32'h8001, 32'h0, 1'b0);
        access(0, "lh_n",  1'b0, 32'h20, 3'b001, 32'h0, 32'hFFFF8001, 1'b0);
        access(0, "lhu",   1'b0, 32'h20, 3'b101, 32'h0, 32'h00008001, 1'b0);
        access(0, "lw2",   1'b0, 32'h20, 3'b010, 32'h0, 32'h12348001, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        access(0, "lw_mis", 1'b0, 32'h11, 3'b010, 32'h0, 32'h0, 1'b1);
`else
        access(0, "lw_mis", 1'b0, 32'h11, 3'b010, 32'h0, 32'h80ADBEEF, 1'b0);
`endif
        access(0, "lw_oor", 1'b0, 32'h100, 3'b010, 32'h0, 32'h0, 1'b1);
        access(0, "sw_oor", 1'b1, 32'h100, 3'b010, 32'h1, 32'h0, 1'b1);
        access(0, "f3_bad", 1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1);
        access(0, "st_bu",  1'b1, 32'h10, 3'b100, 32'hFF, 32'h0, 1'b1);
        access(0, "lw_kept", 1'b0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 1'b0);

        // LATENCY=3: second request held valid is accepted when the first responds
        send(1, 1'b1, 32'h40, 3'b010, 32'hCAFEF00D, w);
        send(1, 1'b0, 32'h40, 3'b010, 32'd0, w);
        chk("lat3_waits", 1, 32'(w), 32'd3);
        expect_rsp(1, "lw_lat3", 32'hCAFEF00D, 1'b0);

        // Reset while a store is in WAIT: response dropped, store kept
        send(1, 1'b1, 32'h34, 3'b010, 32'h5A5A1234, w);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_valid", 1, 32'(rsp_valid[1]), 32'd0);
        chk("rst_ready", 1, 32'(req_ready[1]), 32'd0);
        chk("rst_rdata", 1, rsp_rdata[1], 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (rsp_valid[1]) pulses++;
        end
        chk("rst_no_rsp", 1, 32'(pulses), 32'd0);
        @(posedge clk);
        #1;
        access(1, "lw_persist", 1'b0, 32'h34, 3'b010, 32'h0, 32'h5A5A1234, 1'b0);
        access(0, "lw_persist0", 1'b0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 1'b0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data-memory block for the single-cycle RISC-V core's load/store path. Accepts one load/store request at a time over a valid/ready handshake, and applies RV32I size and sign rules: byte/half/word lane steering and load extension. Inserts a configurable number of wait states and returns a registered response with an error flag. Successor to the plain word-addressed byte-strobe RAM; storage moves behind a sub-module with synchronous read.

## Interface
- `WORDS`, 65536: depth in 32-bit words; power of two, 16..2^30.
- `LATENCY`, 0: extra wait cycles between accept and response, 0..7.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; transfer when `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_funct3`  in  3  RV32I size/sign code.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle response pulse; no backpressure.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  request rejected; no memory side effect.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on accept, go to WAIT if `LATENCY>0`, else to RESP.
  - WAIT: count down `LATENCY` cycles, then go to RESP.
  - RESP: assert `rsp_valid`; on a new accept in the same cycle, behave as IDLE-accept; otherwise return to IDLE.
- `req_ready` = 1 in IDLE and RESP, 0 in WAIT, and forced 0 while `rst_n` is low.
- Word index is `req_addr[31:2]`. Index ≥ `WORDS` is out of range: `rsp_err`=1, no write.
- funct3 decoding:
  - 000 = LB/SB; 001 = LH/SH; 010 = LW/SW; 100 = LBU; 101 = LHU (loads only).
  - 011, 110 and 111, plus 100 or 101 with `req_we`=1: `rsp_err`=1.
- Store steering:
  - SB: `wdata[7:0]` replicated to all lanes; strobe = `1<<addr[1:0]`.
  - SH: `wdata[15:0]` replicated; strobe = `4'b0011<<{addr[1],1'b0}`.
  - SW: strobe = `4'b1111`.
- Load: selected lane shifted to bit 0, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- Only one request is in flight. A load after a store to the same address returns the stored data.

## Timing
- Store writes and load reads occur at the accept edge. The selected word is captured into the response register.
- Response latency: `rsp_valid` is high during cycle accept+1+`LATENCY`.
- Throughput: one request per `LATENCY+1` cycles. With `LATENCY`=0, back-to-back every cycle.
- Reset values: state IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, wait counter 0. Memory contents are not reset.
- Reset mid-operation: the pending response is discarded. A store already accepted stays committed.
- `rsp_rdata` and `rsp_err` hold their values outside `rsp_valid` pulses.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Misaligned access sets `rsp_err`=1 with no write.
  - Misaligned means half with `addr[0]`=1, or word with `addr[1:0]`≠0.
- Not defined:
  - Low address bits are truncated to natural alignment: half ignores `addr[0]`, word ignores `addr[1:0]`.
  - No error is raised for misalignment.

## Structure
- Package `dmem_pkg` holds:
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - FSM state enum;
  - lane-steer/extend functions.
- Sub-module `dmem_array`:
  - `WORDS`×32 storage;
  - 4-bit byte strobe;
  - registered read port, single port.
- The top level holds the FSM, decode, steering and wait counter.

## Test plan
- Reset, SW 0xDEADBEEF @0x10, then LW @0x10 with `LATENCY`=0 -> rsp 0xDEADBEEF, `err`=0, on consecutive cycles.
- SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; other bytes unchanged.
- SH 0x1234 @0x22, then LW @0x20 -> upper half 0x1234; LH @0x22 -> 0x00001234.
- `LATENCY`=3: accept at cycle 0 -> `req_ready` low cycles 1-3, `rsp_valid` cycle 4; `req_valid` held throughout is accepted at cycle 4.
- LW @0x11 with macro -> `err`=1 and memory unchanged; without macro -> word @0x10 returned, `err`=0. Index = `WORDS` -> `err`=1.
- Assert `rst_n`=0 during WAIT -> no `rsp_valid`, outputs 0. A store accepted before reset persists and reads back after reset.
